ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares the single 64 KB ROMulator RAM port between three requesters: the SPI flash loader, the CPU bus interface, and the diagnostic readback path. It fixes priority, supports a loader lock for the boot image copy, and bounds diagnostic starvation with a wait counter. Each granted request becomes one registered RAM cycle with a one-cycle-latency read return. It sits between the requesters and the RAM macro's cs/we/address/data pins.

## Interface

Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 8, RAM data width
- STARVE_LIMIT, 8, losing arbitrations before diag outranks cpu (1..255)

Ports (x ∈ {ld, cpu, dg}):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- x_req  in  1  request; addr/we/wdata held stable until x_ack
- x_we  in  1  1 = write, 0 = read
- x_addr  in  ADDR_W  access address
- x_wdata  in  DATA_W  write data
- x_ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data; valid in the x_ack cycle of a read
- ld_lock  in  1  while high, only ld may be granted
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_address  out  ADDR_W  RAM address
- ram_datain  out  DATA_W  write data to RAM
- ram_dataout  in  DATA_W  RAM read data, valid the cycle after ram_cs
- busy  out  1  high in ACCESS and DONE
- grant_id  out  2  0 = none, 1 = ld, 2 = cpu, 3 = dg; held from grant through DONE

## Operation

- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: evaluate requests each cycle. The winner, in priority order:
  - ld_lock=1: ld only; cpu and dg wait.
  - ld_req: ld.
  - dg_req and starve_cnt==STARVE_LIMIT: dg.
  - cpu_req: cpu.
  - dg_req: dg.
- On a grant, latch the winner's addr/we/wdata onto ram_address/ram_we/ram_datain, set ram_cs=1, set grant_id, and go to ACCESS.
- ACCESS (exactly 1 cycle): at the next edge, drop ram_cs and ram_we, register ram_dataout into rdata, pulse the winner's x_ack, and go to DONE.
- DONE (exactly 1 cycle): x_ack=1. At the next edge, clear x_ack and grant_id and go to IDLE. Requests are not evaluated in DONE, so a requester that drops req in the cycle after ack is never double-granted.
- rdata holds its last value until the next read completes. Writes do not change rdata.
- starve_cnt (8 bits):
  - Increments, saturating at STARVE_LIMIT, on each IDLE grant decision where dg_req=1 and dg loses.
  - Clears when dg is granted or when dg_req=0 in IDLE.
  - Holds while ld_lock=1.
- Requests that arrive while busy wait. Only IDLE decisions count toward starvation.
- A requester that deasserts req before ack leaves the in-flight access to complete. The ack is still pulsed.

## Timing

- Reset (asynchronous, immediate): state=IDLE, ram_cs=0, ram_we=0, ram_address=0, ram_datain=0, rdata=0, all x_ack=0, busy=0, grant_id=0, starve_cnt=0.
  - Reset mid-ACCESS aborts the cycle; no ack is issued.
- Latency: req sampled at edge N, ram_cs high during cycle N+1, x_ack and rdata valid during cycle N+2, IDLE at N+3.
- Back-to-back grants are 3 cycles apart; peak throughput is one access per 3 clk.
- Simultaneous requests in one IDLE cycle: a single grant by the priority rules; the losers remain pending.
- ld_lock rising while a cpu/dg access is in flight: that access completes; the lock applies from the next IDLE.

## Test plan

- Reset mid-ACCESS of a cpu write to 0x1234 -> ram_cs/ram_we fall immediately, no cpu_ack, all outputs at reset values.
- cpu write 0x1234←0xA5, then read 0x1234 -> ram_cs high 1 cycle with ram_we=1, address 0x1234, datain 0xA5; read ack 2 cycles after req with rdata=0xA5; the next grant no sooner than 3 cycles later.
- ld, cpu and dg request in the same IDLE cycle -> grant order ld, cpu, dg; each ack single-cycle; grant_id sequence 1, 2, 3.
- ld_lock=1 with cpu_req and dg_req held for 20 cycles -> no cpu/dg grants; starve_cnt unchanged; on release cpu is granted first.
- STARVE_LIMIT=8, cpu_req and dg_req held continuously -> exactly 8 cpu grants, then one dg grant, starve_cnt=0, then cpu again.
- dg_req dropped before its ack -> access completes, dg_ack pulses once, arbiter returns to IDLE, no second grant to dg.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   Groups the three requester handshakes, the loader lock, the shared read
//   return and the RAM macro pins into one bundle.
//   slave  : the arbiter side (takes requests, drives acks and RAM pins)
//   master : the requester / RAM side (drives requests, RAM read data)
//   Handshake: x_req is a level; x_we/x_addr/x_wdata stay stable while x_req
//   is high and until x_ack. x_ack is a single-cycle pulse. rdata is valid in
//   the x_ack cycle of a read. There is no backpressure on x_ack.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;

    logic              dg_req;
    logic              dg_we;
    logic [ADDR_W-1:0] dg_addr;
    logic [DATA_W-1:0] dg_wdata;
    logic              dg_ack;

    logic              ld_lock;
    logic [DATA_W-1:0] rdata;

    logic              ram_cs;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_datain;
    logic [DATA_W-1:0] ram_dataout;

    logic              busy;
    logic [1:0]        grant_id;

    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dg_req, dg_we, dg_addr, dg_wdata,
        input  ld_lock, ram_dataout,
        output ld_ack, cpu_ack, dg_ack, rdata,
        output ram_cs, ram_we, ram_address, ram_datain,
        output busy, grant_id
    );

    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dg_req, dg_we, dg_addr, dg_wdata,
        output ld_lock, ram_dataout,
        input  ld_ack, cpu_ack, dg_ack, rdata,
        input  ram_cs, ram_we, ram_address, ram_datain,
        input  busy, grant_id
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one RAM port between the SPI flash loader (ld), the CPU bus (cpu)
//   and the diagnostic readback path (dg). Fixed priority ld > cpu > dg, with
//   a starvation counter that lifts dg above cpu after STARVE_LIMIT losses,
//   and a loader lock that admits only ld. Each grant is one registered RAM
//   cycle (ACCESS) followed by an ack cycle (DONE); grants are 3 clk apart.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     bus             ram_port_arbiter_if.slave (requests, acks, RAM pins)
//     dbg_state       current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//     dbg_starve_cnt  current diag starvation count
module ram_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_port_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state,
    output logic [7:0]           dbg_starve_cnt
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_LD   = 2'd1;
    localparam logic [1:0] ID_CPU  = 2'd2;
    localparam logic [1:0] ID_DG   = 2'd3;

    state_t            state_q, state_d;
    logic              ram_cs_q, ram_cs_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_datain_q, ram_datain_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        ack_q, ack_d;        // bit0 ld, bit1 cpu, bit2 dg
    logic              busy_q, busy_d;
    logic [1:0]        grant_q, grant_d;
    logic [7:0]        starve_q, starve_d;

    logic [1:0]        win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Winner of the current IDLE decision and its request fields.
    always_comb begin
        win = ID_NONE;
        if (bus.ld_lock) begin
            if (bus.ld_req) win = ID_LD;
        end else if (bus.ld_req) begin
            win = ID_LD;
        end else if (bus.dg_req && (starve_q == LIMIT)) begin
            win = ID_DG;
        end else if (bus.cpu_req) begin
            win = ID_CPU;
        end else if (bus.dg_req) begin
            win = ID_DG;
        end

        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (win)
            ID_LD: begin
                sel_we    = bus.ld_we;
                sel_addr  = bus.ld_addr;
                sel_wdata = bus.ld_wdata;
            end
            ID_CPU: begin
                sel_we    = bus.cpu_we;
                sel_addr  = bus.cpu_addr;
                sel_wdata = bus.cpu_wdata;
            end
            ID_DG: begin
                sel_we    = bus.dg_we;
                sel_addr  = bus.dg_addr;
                sel_wdata = bus.dg_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        ram_cs_d      = ram_cs_q;
        ram_we_d      = ram_we_q;
        ram_address_d = ram_address_q;
        ram_datain_d  = ram_datain_q;
        rdata_d       = rdata_q;
        ack_d         = ack_q;
        busy_d        = busy_q;
        grant_d       = grant_q;
        starve_d      = starve_q;

        case (state_q)
            S_IDLE: begin
                // The lock freezes the counter; otherwise each decision with
                // dg waiting either clears it (dg won) or counts a loss.
                if (!bus.ld_lock) begin
                    if (!bus.dg_req || win == ID_DG) begin
                        starve_d = 8'd0;
                    end else if (starve_q != LIMIT) begin
                        starve_d = starve_q + 8'd1;
                    end
                end
                if (win != ID_NONE) begin
                    ram_cs_d      = 1'b1;
                    ram_we_d      = sel_we;
                    ram_address_d = sel_addr;
                    ram_datain_d  = sel_wdata;
                    grant_d       = win;
                    busy_d        = 1'b1;
                    state_d       = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_cs_d = 1'b0;
                ram_we_d = 1'b0;
                if (!ram_we_q) rdata_d = bus.ram_dataout;
                ack_d   = {grant_q == ID_DG, grant_q == ID_CPU, grant_q == ID_LD};
                state_d = S_DONE;
            end
            S_DONE: begin
                ack_d   = 3'b000;
                grant_d = ID_NONE;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ram_cs_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_address_q <= '0;
            ram_datain_q  <= '0;
            rdata_q       <= '0;
            ack_q         <= 3'b000;
            busy_q        <= 1'b0;
            grant_q       <= ID_NONE;
            starve_q      <= 8'd0;
        end else begin
            state_q       <= state_d;
            ram_cs_q      <= ram_cs_d;
            ram_we_q      <= ram_we_d;
            ram_address_q <= ram_address_d;
            ram_datain_q  <= ram_datain_d;
            rdata_q       <= rdata_d;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
            grant_q       <= grant_d;
            starve_q      <= starve_d;
        end
    end

    assign bus.ram_cs      = ram_cs_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_datain  = ram_datain_q;
    assign bus.rdata       = rdata_q;
    assign bus.ld_ack      = ack_q[0];
    assign bus.cpu_ack     = ack_q[1];
    assign bus.dg_ack      = ack_q[2];
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_q;
    assign dbg_state       = state_q;
    assign dbg_starve_cnt  = starve_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
    localparam int LIMIT = 8;

    logic clk;
    logic rst;
    logic [1:0] dbg_state;
    logic [7:0] dbg_starve_cnt;

    ram_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- RAM macro model ----------------
    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    always @(posedge clk) if (bus.ram_cs && bus.ram_we) mem[bus.ram_address] = bus.ram_datain;
    assign bus.ram_dataout = mem[bus.ram_address];

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // Phase 0 idle, 1 RAM cycle, 2 ack cycle. Winner follows the priority list.
    int         m_phase, m_who, m_starve;
    logic       m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wd, m_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_who = 0; m_starve = 0;
            m_we = 0; m_addr = 0; m_wd = 0; m_rdata = 0;
        end else begin
            case (m_phase)
                0: begin
                    int w;
                    w = 0;
                    if (bus.ld_lock)                             w = bus.ld_req ? 1 : 0;
                    else if (bus.ld_req)                         w = 1;
                    else if (bus.dg_req && m_starve == LIMIT)    w = 3;
                    else if (bus.cpu_req)                        w = 2;
                    else if (bus.dg_req)                         w = 3;
                    if (!bus.ld_lock) begin
                        if (!bus.dg_req || w == 3) m_starve = 0;
                        else m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
                    end
                    if (w != 0) begin
                        m_who = w;
                        m_phase = 1;
                        case (w)
                            1: begin m_we = bus.ld_we;  m_addr = bus.ld_addr;  m_wd = bus.ld_wdata;  end
                            2: begin m_we = bus.cpu_we; m_addr = bus.cpu_addr; m_wd = bus.cpu_wdata; end
                            default: begin m_we = bus.dg_we; m_addr = bus.dg_addr; m_wd = bus.dg_wdata; end
                        endcase
                    end
                end
                1: begin
                    if (m_we) ref_mem[m_addr] = m_wd;
                    else m_rdata = ref_mem[m_addr];
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("ram_cs",  32'(bus.ram_cs),      32'(m_phase == 1));
            chk("ram_we",  32'(bus.ram_we),      32'(m_phase == 1 && m_we));
            chk("ram_addr", 32'(bus.ram_address), 32'(m_addr));
            chk("ram_din", 32'(bus.ram_datain),  32'(m_wd));
            chk("rdata",   32'(bus.rdata),       32'(m_rdata));
            chk("ld_ack",  32'(bus.ld_ack),      32'(m_phase == 2 && m_who == 1));
            chk("cpu_ack", 32'(bus.cpu_ack),     32'(m_phase == 2 && m_who == 2));
            chk("dg_ack",  32'(bus.dg_ack),      32'(m_phase == 2 && m_who == 3));
            chk("busy",    32'(bus.busy),        32'(m_phase != 0));
            chk("grant_id", 32'(bus.grant_id),   32'((m_phase != 0) ? m_who : 0));
            chk("state",   32'(dbg_state),       32'(m_phase));
            chk("starve",  32'(dbg_starve_cnt),  32'(m_starve));
        end
    end

    // ---------------- monitor (grant/ack logs, grant spacing) ----------------
    int gid_log[$];
    int ack_log[$];
    int ack_cnt[4];
    int last_cs_cyc = -1;
    int min_gap = 1000;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_cs) begin
                gid_log.push_back(int'(bus.grant_id));
                if (last_cs_cyc >= 0 && cyc - last_cs_cyc < min_gap) min_gap = cyc - last_cs_cyc;
                last_cs_cyc = cyc;
            end
            if (bus.ld_ack)  begin ack_log.push_back(1); ack_cnt[1]++; end
            if (bus.cpu_ack) begin ack_log.push_back(2); ack_cnt[2]++; end
            if (bus.dg_ack)  begin ack_log.push_back(3); ack_cnt[3]++; end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic we, input logic [15:0] a, input logic [7:0] d);
        case (id)
            1: begin bus.ld_we = we;  bus.ld_addr = a;  bus.ld_wdata = d;  bus.ld_req = 1'b1;  end
            2: begin bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1'b1; end
            default: begin bus.dg_we = we; bus.dg_addr = a; bus.dg_wdata = d; bus.dg_req = 1'b1; end
        endcase
    endtask

    task automatic drop_req(input int id);
        case (id)
            1: bus.ld_req = 1'b0;
            2: bus.cpu_req = 1'b0;
            default: bus.dg_req = 1'b0;
        endcase
    endtask

    function automatic logic ack_of(input int id);
        case (id)
            1: return bus.ld_ack;
            2: return bus.cpu_ack;
            default: return bus.dg_ack;
        endcase
    endfunction

    // Raise a request, hold it until its ack, then drop it.
    task automatic do_req(input int id, input logic we, input logic [15:0] a, input logic [7:0] d);
        bit got;
        got = 0;
        set_req(id, we, a, d);
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (ack_of(id)) got = 1;
        end
        chk("req_ack_timeout", 32'(got), 32'd1);
        drop_req(id);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base, lat, dgc, cpc;
        bit got, seen_dg;
        int exp_seq[10];

        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        {bus.ld_req, bus.ld_we, bus.ld_addr, bus.ld_wdata} = '0;
        {bus.cpu_req, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata} = '0;
        {bus.dg_req, bus.dg_we, bus.dg_addr, bus.dg_wdata} = '0;
        bus.ld_lock = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_cs", 32'(bus.ram_cs), 32'd0);
        chk("reset_gid", 32'(bus.grant_id), 32'd0);
        rst = 1'b0;
        tick();

        // cpu write 0x1234 <- 0xA5, then read it back
        set_req(2, 1'b1, 16'h1234, 8'hA5);
        tick();
        chk("wr_cs", 32'(bus.ram_cs), 32'd1);
        chk("wr_we", 32'(bus.ram_we), 32'd1);
        chk("wr_addr", 32'(bus.ram_address), 32'h1234);
        chk("wr_din", 32'(bus.ram_datain), 32'hA5);
        chk("wr_gid", 32'(bus.grant_id), 32'd2);
        tick();
        chk("wr_ack", 32'(bus.cpu_ack), 32'd1);
        chk("wr_cs_drop", 32'(bus.ram_cs), 32'd0);
        drop_req(2);
        tick();
        chk("wr_ack_single", 32'(bus.cpu_ack), 32'd0);
        set_req(2, 1'b0, 16'h1234, 8'h00);
        lat = 0; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            lat++;
            if (bus.cpu_ack) got = 1;
        end
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_data", 32'(bus.rdata), 32'hA5);
        drop_req(2);
        tick();
        tick();

        // simultaneous ld/cpu/dg
        base = gid_log.size();
        fork
            do_req(1, 1'b0, 16'h0100, 8'h00);
            do_req(2, 1'b1, 16'h0200, 8'h11);
            do_req(3, 1'b0, 16'h1234, 8'h00);
        join
        tick();
        chk("simul_count", 32'(gid_log.size() - base), 32'd3);
        chk("simul_gid0", 32'(gid_log[base]),   32'd1);
        chk("simul_gid1", 32'(gid_log[base+1]), 32'd2);
        chk("simul_gid2", 32'(gid_log[base+2]), 32'd3);
        chk("simul_ack_order", 32'(ack_log[ack_log.size()-1]), 32'd3);
        chk("simul_dg_rdata", 32'(bus.rdata), 32'hA5);
        tick();

        // ld_lock rising during a cpu access; cpu/dg held for 20 cycles
        base = gid_log.size();
        cpc = ack_cnt[2];
        set_req(2, 1'b0, 16'h0200, 8'h00);
        set_req(3, 1'b0, 16'h0100, 8'h00);
        tick();
        bus.ld_lock = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("lock_grants", 32'(gid_log.size() - base), 32'd1);
        chk("lock_inflight_ack", 32'(ack_cnt[2] - cpc), 32'd1);
        chk("lock_starve_hold", 32'(dbg_starve_cnt), 32'd1);
        chk("lock_rdata", 32'(bus.rdata), 32'h11);
        bus.ld_lock = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (gid_log.size() > base + 1) got = 1;
        end
        chk("unlock_grant_timeout", 32'(got), 32'd1);
        chk("unlock_first_cpu", 32'(gid_log[base+1]), 32'd2);
        drop_req(2);
        drop_req(3);
        for (int i = 0; i < 4; i++) tick();

        // starvation: cpu writes and dg reads held continuously
        base = gid_log.size();
        seen_dg = 0;
        set_req(2, 1'b1, 16'h0040, 8'h3C);
        set_req(3, 1'b0, 16'h0040, 8'h00);
        for (int i = 0; i < 60 && gid_log.size() < base + 10; i++) begin
            tick();
            if (bus.ram_cs && bus.grant_id == 2'd3 && !seen_dg) begin
                seen_dg = 1;
                chk("starve_clear", 32'(dbg_starve_cnt), 32'd0);
            end
            if (bus.dg_ack) chk("starve_dg_rdata", 32'(bus.rdata), 32'h3C);
        end
        drop_req(2);
        drop_req(3);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 10; i++) exp_seq[i] = 2;
        exp_seq[8] = 3;
        chk("starve_grants", 32'(gid_log.size() >= base + 10), 32'd1);
        if (gid_log.size() >= base + 10)
            for (int i = 0; i < 10; i++) chk("starve_seq", 32'(gid_log[base+i]), 32'(exp_seq[i]));

        // dg drops its request before its ack
        base = gid_log.size();
        dgc = ack_cnt[3];
        set_req(3, 1'b0, 16'h0200, 8'h00);
        tick();
        drop_req(3);
        chk("dgdrop_cs", 32'(bus.ram_cs), 32'd1);
        chk("dgdrop_gid", 32'(bus.grant_id), 32'd3);
        for (int i = 0; i < 8; i++) tick();
        chk("dgdrop_acks", 32'(ack_cnt[3] - dgc), 32'd1);
        chk("dgdrop_grants", 32'(gid_log.size() - base), 32'd1);
        chk("dgdrop_idle", 32'(dbg_state), 32'd0);
        chk("dgdrop_rdata", 32'(bus.rdata), 32'h11);

        chk("min_grant_gap", 32'(min_gap), 32'd3);

        // reset in the middle of a cpu write to 0x1234
        cpc = ack_cnt[2];
        set_req(2, 1'b1, 16'h1234, 8'h5A);
        tick();
        chk("rst_pre_cs", 32'(bus.ram_cs), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_cs", 32'(bus.ram_cs), 32'd0);
        chk("rst_we", 32'(bus.ram_we), 32'd0);
        chk("rst_addr", 32'(bus.ram_address), 32'd0);
        chk("rst_din", 32'(bus.ram_datain), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_acks", 32'({bus.ld_ack, bus.cpu_ack, bus.dg_ack}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_gid", 32'(bus.grant_id), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_starve", 32'(dbg_starve_cnt), 32'd0);
        drop_req(2);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_no_ack", 32'(ack_cnt[2] - cpc), 32'd0);
        chk("rst_no_write", 32'(mem[16'h1234]), 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
